alu_cmd_sequencer: RTL

//  Command-side master of ArithmeticLogicUnit: accepts commands on a valid/ready port and drives A/B/FunSel/WF.

---
 rtl/alu_ctrl_pkg.sv | 51 +++++
 rtl/alu_cond_eval.sv | 47 ++++
 rtl/alu_cmd_sequencer.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_ctrl_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | alu_ctrl_pkg                                                                |
// | Shared ALU function selects, command opcodes, condition codes, FSM states.  |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
package alu_ctrl_pkg;

  localparam logic [4:0] FS_NONE    = 5'b00000;
  localparam logic [4:0] FS_PASSA16 = 5'b10000;
  localparam logic [4:0] FS_ADD16   = 5'b10100;
  localparam logic [4:0] FS_SUB16   = 5'b10110;
  localparam logic [4:0] FS_LSL16   = 5'b11011;

  typedef enum logic [1:0] {
    OP_SINGLE = 2'b00,
    OP_CMP    = 2'b01,
    OP_MUL8   = 2'b10,
    OP_RSVD   = 2'b11
  } cmd_op_e;

  localparam logic [3:0] COND_EQ = 4'd0;
  localparam logic [3:0] COND_NE = 4'd1;
  localparam logic [3:0] COND_CS = 4'd2;
  localparam logic [3:0] COND_CC = 4'd3;
  localparam logic [3:0] COND_MI = 4'd4;
  localparam logic [3:0] COND_PL = 4'd5;
  localparam logic [3:0] COND_VS = 4'd6;
  localparam logic [3:0] COND_VC = 4'd7;
  localparam logic [3:0] COND_LT = 4'd8;
  localparam logic [3:0] COND_GE = 4'd9;
  localparam logic [3:0] COND_GT = 4'd10;
  localparam logic [3:0] COND_LE = 4'd11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_FLAGS   = 3'd2,
    ST_MUL_ADD = 3'd3,
    ST_MUL_SHL = 3'd4,
    ST_RESP    = 3'd5
  } state_e;

  // Flag vector layout is {Z,C,N,O}
  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_O = 0;

endpackage
`default_nettype wire

// File: rtl/alu_cond_eval.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | alu_cond_eval                                                               |
// | Combinational condition-code evaluation against ALU flags {Z,C,N,O}.        |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module alu_cond_eval
  import alu_ctrl_pkg::*;
(
  input  logic [3:0] i_flags,
  input  logic [3:0] i_cond,
  output logic       o_taken
);

  logic w_z;
  logic w_c;
  logic w_n;
  logic w_o;
  logic w_lt;

  assign w_z  = i_flags[FLAG_Z];
  assign w_c  = i_flags[FLAG_C];
  assign w_n  = i_flags[FLAG_N];
  assign w_o  = i_flags[FLAG_O];
  assign w_lt = w_n ^ w_o;

  always_comb begin
    o_taken = 1'b1;
    case (i_cond)
      COND_EQ: o_taken = w_z;
      COND_NE: o_taken = ~w_z;
      COND_CS: o_taken = w_c;
      COND_CC: o_taken = ~w_c;
      COND_MI: o_taken = w_n;
      COND_PL: o_taken = ~w_n;
      COND_VS: o_taken = w_o;
      COND_VC: o_taken = ~w_o;
      COND_LT: o_taken = w_lt;
      COND_GE: o_taken = ~w_lt;
      COND_GT: o_taken = ~w_z & ~w_lt;
      COND_LE: o_taken = w_z | w_lt;
      default: o_taken = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | alu_cmd_sequencer                                                           |
// | Command master for the ALU: single ops, compare/condition, 8x8 multiply.    |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module alu_cmd_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int MUL_STEPS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic [1:0]  i_cmd_op,
  input  logic [4:0]  i_cmd_fun,
  input  logic [3:0]  i_cmd_cond,
  input  logic [15:0] i_cmd_a,
  input  logic [15:0] i_cmd_b,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [15:0] o_rsp_result,
  output logic [3:0]  o_rsp_flags,
  output logic        o_rsp_taken,
  output logic        o_rsp_err,
  output logic [15:0] o_alu_a,
  output logic [15:0] o_alu_b,
  output logic [4:0]  o_alu_funsel,
  output logic        o_alu_wf,
  input  logic [15:0] i_alu_out,
  input  logic [3:0]  i_alu_flags
);

  localparam int CNT_W = $clog2(MUL_STEPS + 1);

  state_e         r_state;
  state_e         w_state_nxt;
  cmd_op_e        r_op;
  cmd_op_e        w_cmd_op;
  logic [4:0]     r_fun;
  logic [3:0]     r_cond;
  logic [15:0]    r_a;
  logic [15:0]    r_b;
  logic [15:0]    r_acc;
  logic [15:0]    r_mcand;
  logic [7:0]     r_mplier;
  logic [CNT_W-1:0] r_cnt;
  logic           r_rsp_valid;
  logic [15:0]    r_rsp_result;
  logic [3:0]     r_rsp_flags;
  logic           r_rsp_taken;
  logic           r_rsp_err;

  logic w_accept;
  logic w_mul_last;
  logic w_rsp_done;
  logic w_taken;

  assign w_cmd_op   = cmd_op_e'(i_cmd_op);
  assign w_accept   = (r_state == ST_IDLE) && i_cmd_valid;
  assign w_mul_last = (r_cnt == CNT_W'(MUL_STEPS - 1));
  assign w_rsp_done = r_rsp_valid && i_rsp_ready;

  alu_cond_eval u_cond_eval (
    .i_flags (i_alu_flags),
    .i_cond  (r_cond),
    .o_taken (w_taken)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // The ALU port is only driven while the sequencer owns it; WF only in ISSUE.
  always_comb begin
    w_state_nxt  = r_state;
    o_cmd_ready  = 1'b0;
    o_alu_a      = 16'h0000;
    o_alu_b      = 16'h0000;
    o_alu_funsel = FS_NONE;
    o_alu_wf     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_cmd_ready = 1'b1;
        if (i_cmd_valid) begin
          case (w_cmd_op)
            OP_SINGLE, OP_CMP: w_state_nxt = ST_ISSUE;
            OP_MUL8:           w_state_nxt = ST_MUL_ADD;
            default:           w_state_nxt = ST_RESP;
          endcase
        end
      end
      ST_ISSUE: begin
        o_alu_wf    = 1'b1;
        w_state_nxt = ST_FLAGS;
        case (r_op)
          OP_SINGLE: begin
            o_alu_funsel = r_fun;
            o_alu_a      = r_a;
            o_alu_b      = r_b;
          end
          OP_CMP: begin
            o_alu_funsel = FS_SUB16;
            o_alu_a      = r_a;
            o_alu_b      = r_b;
          end
          default: begin
            o_alu_funsel = FS_PASSA16;
            o_alu_a      = r_acc;
          end
        endcase
      end
      ST_FLAGS: w_state_nxt = ST_RESP;
      ST_MUL_ADD: begin
        o_alu_funsel = FS_ADD16;
        o_alu_a      = r_acc;
        o_alu_b      = r_mcand;
        w_state_nxt  = ST_MUL_SHL;
      end
      ST_MUL_SHL: begin
        o_alu_funsel = FS_LSL16;
        o_alu_a      = r_mcand;
        w_state_nxt  = w_mul_last ? ST_ISSUE : ST_MUL_ADD;
      end
      ST_RESP: begin
        if (w_rsp_done) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op         <= OP_SINGLE;
      r_fun        <= 5'b00000;
      r_cond       <= 4'h0;
      r_a          <= 16'h0000;
      r_b          <= 16'h0000;
      r_acc        <= 16'h0000;
      r_mcand      <= 16'h0000;
      r_mplier     <= 8'h00;
      r_cnt        <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= 16'h0000;
      r_rsp_flags  <= 4'h0;
      r_rsp_taken  <= 1'b0;
      r_rsp_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op     <= w_cmd_op;
        r_fun    <= i_cmd_fun;
        r_cond   <= i_cmd_cond;
        r_a      <= i_cmd_a;
        r_b      <= i_cmd_b;
        r_acc    <= 16'h0000;
        r_mcand  <= {8'h00, i_cmd_a[7:0]};
        r_mplier <= i_cmd_b[7:0];
        r_cnt    <= '0;
        if (w_cmd_op == OP_RSVD) begin
          r_rsp_valid <= 1'b1;
          r_rsp_err   <= 1'b1;
        end
      end
      case (r_state)
        ST_ISSUE: r_rsp_result <= i_alu_out;
        // Flags register inside the ALU updates on the ISSUE edge, so sample one cycle later
        ST_FLAGS: begin
          r_rsp_flags <= i_alu_flags;
          r_rsp_taken <= (r_op == OP_CMP) && w_taken;
          r_rsp_valid <= 1'b1;
        end
        ST_MUL_ADD: begin
          if (r_mplier[0]) begin
            r_acc <= i_alu_out;
          end
        end
        ST_MUL_SHL: begin
          r_mcand  <= i_alu_out;
          r_mplier <= {1'b0, r_mplier[7:1]};
          r_cnt    <= r_cnt + CNT_W'(1);
        end
        ST_RESP: begin
          if (w_rsp_done) begin
            r_rsp_valid  <= 1'b0;
            r_rsp_result <= 16'h0000;
            r_rsp_flags  <= 4'h0;
            r_rsp_taken  <= 1'b0;
            r_rsp_err    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_rsp_valid  = r_rsp_valid;
  assign o_rsp_result = r_rsp_result;
  assign o_rsp_flags  = r_rsp_flags;
  assign o_rsp_taken  = r_rsp_taken;
  assign o_rsp_err    = r_rsp_err;

endmodule
`default_nettype wire
